// File: rtl/miner_ctrl_pkg.sv
// Shared definitions for the header loader and the shift timer: controller
// state encoding, frame geometry and the start-of-frame marker word.
package miner_ctrl_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned MID_WORDS   = 8;
  localparam int unsigned TOTAL_WORDS = 24;
  localparam int unsigned FRAME_W     = WORD_W * TOTAL_WORDS;   // 768
  localparam int unsigned MID_W       = WORD_W * MID_WORDS;     // 256
  localparam int unsigned BLOCK_W     = FRAME_W - MID_W;        // 512

  localparam logic [WORD_W-1:0] START_WORD = 32'hA5A5_5A5A;

  // 3'b101 and 3'b111 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    SHIFT_MID = 3'b001,
    SHIFT_REM = 3'b010,
    LAUNCH    = 3'b011,
    HASHING   = 3'b100,
    ERROR     = 3'b110
  } ctrl_state_e;

  // True for the two states in which frame words are being collected.
  function automatic logic is_capture_state(input ctrl_state_e s);
    return (s == SHIFT_MID) || (s == SHIFT_REM);
  endfunction

endpackage

// File: rtl/word_shift_reg.sv
// Word-wide capture shift register with parallel output. Each enabled cycle
// shifts the contents up by one word and inserts data_in at the bottom, so the
// first word captured ends up in the most significant slot.
module word_shift_reg
  import miner_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = TOTAL_WORDS,
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [WIDTH-1:0]       data_in,
  output logic [DEPTH*WIDTH-1:0] par_out
);

  logic [DEPTH*WIDTH-1:0] sr_q;
  logic [DEPTH*WIDTH-1:0] sr_d;

  // Shift one word in when enabled, otherwise hold.
  always_comb begin
    sr_d = sr_q;
    if (en) begin
      sr_d = {sr_q[DEPTH*WIDTH-WIDTH-1:0], data_in};
    end else begin
      sr_d = sr_q;
    end
  end

  // Storage register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign par_out = sr_q;

endmodule

// File: rtl/header_load_ctrl.sv
// Header load controller: detects the start word on the host link, collects
// the 24-word header with the help of the external shift timer, publishes it
// as midstate/block_words and launches the hash core.
module header_load_ctrl
  import miner_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [WORD_W-1:0]  data_in,
  input  logic               data_valid,
  input  logic               midstate_shifts_done,
  input  logic               remaining_shifts_done,
  input  logic               hash_done,
  output logic [2:0]         controller_state,
  output logic               start_found,
  output logic [MID_W-1:0]   midstate,
  output logic [BLOCK_W-1:0] block_words,
  output logic               hash_start,
  output logic               frame_error
);

  logic [WORD_W-1:0]  in_q,          in_d;
  logic               valid_q,       valid_d;
  ctrl_state_e        state_q,       state_d;
  logic               hash_start_q,  hash_start_d;
  logic               frame_error_q, frame_error_d;
  logic [MID_W-1:0]   midstate_q,    midstate_d;
  logic [BLOCK_W-1:0] block_q,       block_d;

  logic               start_det;
  logic               mid_done_eff;
  logic               rem_done_eff;
  logic               capture_cycle;
  logic               shift_en;
  logic               frame_drop;
  logic               load_out;
  logic [FRAME_W-1:0] frame_words;

  // Input stage: the link word and its valid flag are retimed once before use.
  always_comb begin
    in_d    = data_in;
    valid_d = data_valid;
  end

  // Input stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      in_q    <= in_d;
      valid_q <= valid_d;
    end
  end

  // Decode of the retimed word and of the timer flags; timer flags only
  // count in the state that owns them.
  always_comb begin
    start_det     = (state_q == IDLE) && valid_q && (in_q == START_WORD);
    mid_done_eff  = (state_q == SHIFT_MID) && midstate_shifts_done;
    rem_done_eff  = (state_q == SHIFT_REM) && remaining_shifts_done;
    capture_cycle = is_capture_state(state_q) && !rem_done_eff;
    shift_en      = capture_cycle && valid_q;
    frame_drop    = capture_cycle && !valid_q;
  end

  word_shift_reg #(
    .DEPTH (TOTAL_WORDS),
    .WIDTH (WORD_W)
  ) u_word_shift_reg (
    .clk     (clk),
    .rst     (rst),
    .en      (shift_en),
    .data_in (in_q),
    .par_out (frame_words)
  );

  // Controller next-state logic; a missing word aborts the frame, and the
  // header outputs are refreshed on the edge into LAUNCH so they are already
  // valid while hash_start is high.
  always_comb begin
    state_d       = state_q;
    frame_error_d = frame_error_q;
    hash_start_d  = 1'b0;
    load_out      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_det) begin
          state_d       = SHIFT_MID;
          frame_error_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT_MID: begin
        if (frame_drop) begin
          state_d       = ERROR;
          frame_error_d = 1'b1;
        end else if (mid_done_eff) begin
          state_d = SHIFT_REM;
        end else begin
          state_d = SHIFT_MID;
        end
      end
      SHIFT_REM: begin
        if (rem_done_eff) begin
          state_d      = LAUNCH;
          hash_start_d = 1'b1;
          load_out     = 1'b1;
        end else if (frame_drop) begin
          state_d       = ERROR;
          frame_error_d = 1'b1;
        end else begin
          state_d = SHIFT_REM;
        end
      end
      LAUNCH: begin
        state_d = HASHING;
      end
      HASHING: begin
        if (hash_done) begin
          state_d = IDLE;
        end else begin
          state_d = HASHING;
        end
      end
      ERROR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Header output capture from the completed shift register.
  always_comb begin
    if (load_out) begin
      midstate_d = frame_words[FRAME_W-1:BLOCK_W];
      block_d    = frame_words[BLOCK_W-1:0];
    end else begin
      midstate_d = midstate_q;
      block_d    = block_q;
    end
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      hash_start_q  <= 1'b0;
      frame_error_q <= 1'b0;
      midstate_q    <= '0;
      block_q       <= '0;
    end else begin
      state_q       <= state_d;
      hash_start_q  <= hash_start_d;
      frame_error_q <= frame_error_d;
      midstate_q    <= midstate_d;
      block_q       <= block_d;
    end
  end

  assign controller_state = state_q;
  assign start_found      = start_det;
  assign hash_start       = hash_start_q;
  assign frame_error      = frame_error_q;
  assign midstate         = midstate_q;
  assign block_words      = block_q;

endmodule

// File: tb/tb_header_load_ctrl.sv
// Bench for header_load_ctrl: includes a shift-timer model and a hash-core
// model; completed frames are queued with their expected header and launch
// cycle and compared when hash_start appears.
module tb_header_load_ctrl;
  import miner_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  data_in;
  logic         data_valid;
  logic         midstate_shifts_done;
  logic         remaining_shifts_done;
  logic         hash_done;
  logic [2:0]   controller_state;
  logic         start_found;
  logic [255:0] midstate;
  logic [511:0] block_words;
  logic         hash_start;
  logic         frame_error;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int hs_seen  = 0;
  int hs_expected = 0;

  typedef struct {
    logic [255:0] mid;
    logic [511:0] blk;
    int           at;
  } exp_t;
  exp_t sb_q[$];

  logic [5:0] tmr_cnt;
  logic [4:0] hd_cnt;

  always #5 clk = ~clk;

  header_load_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .data_in               (data_in),
    .data_valid            (data_valid),
    .midstate_shifts_done  (midstate_shifts_done),
    .remaining_shifts_done (remaining_shifts_done),
    .hash_done             (hash_done),
    .controller_state      (controller_state),
    .start_found           (start_found),
    .midstate              (midstate),
    .block_words           (block_words),
    .hash_start            (hash_start),
    .frame_error           (frame_error)
  );

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Shift timer: cleared by start_found, counts while collecting words.
  always @(posedge clk or posedge rst) begin
    if (rst) tmr_cnt <= 6'd0;
    else if (start_found) tmr_cnt <= 6'd0;
    else if ((controller_state == 3'b001 || controller_state == 3'b010) && tmr_cnt != 6'd63)
      tmr_cnt <= tmr_cnt + 6'd1;
  end
  assign midstate_shifts_done  = (tmr_cnt == 6'd8);
  assign remaining_shifts_done = (tmr_cnt == 6'd24);

  // Hash core: hash_done pulses ten cycles into the hash.
  always @(posedge clk or posedge rst) begin
    if (rst) hd_cnt <= 5'd0;
    else if (hash_start) hd_cnt <= 5'd10;
    else if (hd_cnt != 5'd0) hd_cnt <= hd_cnt - 5'd1;
  end
  assign hash_done = (hd_cnt == 5'd1);

  task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every hash_start must match the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && hash_start) begin
      hs_seen++;
      if (sb_q.size() == 0) begin
        chk("hs_unexpected", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        chk("hs_cycle", cyc, e.at);
        chk("sb_midstate", midstate, e.mid);
        chk("sb_block_words", block_words, e.blk);
      end
    end
  end

  function automatic logic [255:0] frame_mid(input logic [31:0] w [24]);
    logic [255:0] m = '0;
    for (int k = 0; k < 8; k++) m = {m[223:0], w[k]};
    return m;
  endfunction

  function automatic logic [511:0] frame_blk(input logic [31:0] w [24]);
    logic [511:0] b = '0;
    for (int k = 8; k < 24; k++) b = {b[479:0], w[k]};
    return b;
  endfunction

  task automatic drive(input logic [31:0] w, input logic v);
    @(negedge clk);
    data_in    = w;
    data_valid = v;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (controller_state != 3'b000 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", controller_state, 3'b000);
  endtask

  // Start word followed by 24 words; drop_at >= 0 sends that word with valid low.
  task automatic send_frame(input logic [31:0] w [24], input int drop_at, output int t0);
    drive(START_WORD, 1'b1);
    t0 = cyc;
    if (drop_at < 0) begin
      exp_t e;
      e.mid = frame_mid(w);
      e.blk = frame_blk(w);
      e.at  = t0 + 27;
      sb_q.push_back(e);
      hs_expected++;
    end
    for (int k = 0; k < 24; k++) begin
      drive(w[k], (k == drop_at) ? 1'b0 : 1'b1);
      if (k == 0) chk("start_found_t1", start_found, 1'b1);
      if (k == 1) begin
        chk("shift_mid_t2", controller_state, 3'b001);
        chk("ferr_clear_t2", frame_error, 1'b0);
      end
      if (k == drop_at) break;
    end
    drive(32'h0, 1'b0);
  endtask

  logic [31:0] wa [24];
  logic [31:0] wb [24];
  logic [255:0] mid_a;
  logic [511:0] blk_a;
  int t0;

  initial begin
    rst = 1'b1;
    data_in = 32'h0;
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", controller_state, 3'b000);
    chk("rst_start_found", start_found, 1'b0);
    chk("rst_hash_start", hash_start, 1'b0);
    chk("rst_frame_error", frame_error, 1'b0);
    chk("rst_midstate", midstate, 256'h0);
    chk("rst_block_words", block_words, 512'h0);
    rst = 1'b0;
    idle_n_loop: for (int i = 0; i < 2; i++) drive(32'h0, 1'b0);

    // Near-miss words in IDLE.
    drive(32'hA5A5_5A5B, 1'b1);
    drive(START_WORD, 1'b0);
    chk("nearmiss_sf", start_found, 1'b0);
    chk("nearmiss_state", controller_state, 3'b000);
    drive(32'h0, 1'b0);
    chk("novalid_sf", start_found, 1'b0);
    chk("novalid_state", controller_state, 3'b000);
    drive(32'h0, 1'b0);
    chk("after_state", controller_state, 3'b000);

    // Frame A: counting words 0x00..0x17.
    for (int k = 0; k < 24; k++) wa[k] = k;
    mid_a = frame_mid(wa);
    blk_a = frame_blk(wa);
    send_frame(wa, -1, t0);
    wait_cyc(t0 + 28);
    chk("hashing_state", controller_state, 3'b100);
    wait_idle(40);
    chk("fa_mid_w0", midstate[255:224], 32'h0);
    chk("fa_blk_w23", block_words[31:0], 32'h17);

    // Frame with valid dropped at word 12.
    for (int k = 0; k < 24; k++) wb[k] = $urandom;
    send_frame(wb, 12, t0);
    wait_cyc(t0 + 15);
    chk("err_state", controller_state, 3'b110);
    chk("err_flag", frame_error, 1'b1);
    chk("err_no_hs", hash_start, 1'b0);
    wait_cyc(t0 + 16);
    chk("err_to_idle", controller_state, 3'b000);
    chk("err_sticky", frame_error, 1'b1);
    chk("err_keep_mid", midstate, mid_a);
    chk("err_keep_blk", block_words, blk_a);
    drive(32'h0, 1'b0);
    drive(32'h0, 1'b0);
    chk("err_still_sticky", frame_error, 1'b1);

    // Frame B, then a start word during its hash.
    for (int k = 0; k < 24; k++) wb[k] = $urandom;
    send_frame(wb, -1, t0);
    wait_cyc(t0 + 29);
    chk("b_hashing", controller_state, 3'b100);
    drive(START_WORD, 1'b1);
    drive(32'h0, 1'b0);
    chk("hashing_ignore_sf", start_found, 1'b0);
    chk("hashing_ignore_st", controller_state, 3'b100);
    wait_idle(40);

    // Frame C accepted after hash_done.
    for (int k = 0; k < 24; k++) wb[k] = $urandom;
    send_frame(wb, -1, t0);
    wait_idle(80);

    // Reset in the middle of a frame.
    drive(START_WORD, 1'b1);
    t0 = cyc;
    for (int k = 0; k < 6; k++) drive($urandom, 1'b1);
    rst = 1'b1;
    #1;
    chk("mrst_state", controller_state, 3'b000);
    chk("mrst_start_found", start_found, 1'b0);
    chk("mrst_hash_start", hash_start, 1'b0);
    chk("mrst_frame_error", frame_error, 1'b0);
    chk("mrst_midstate", midstate, 256'h0);
    chk("mrst_block_words", block_words, 512'h0);
    @(negedge clk);
    rst = 1'b0;
    data_valid = 1'b0;
    drive(32'h0, 1'b0);

    // Fresh frame after reset.
    for (int k = 0; k < 24; k++) wb[k] = $urandom;
    send_frame(wb, -1, t0);
    wait_idle(80);
    drive(32'h0, 1'b0);

    chk("sb_empty", sb_q.size(), 0);
    chk("hs_count", hs_seen, hs_expected);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
